axi_cmd_master: RTL and testbench

AXI_CMD_MASTER -- requirements
Module: axi_cmd_master

---
 rtl/axi_pkg.sv | 32 +++
 rtl/axi_cmd_master.sv | 221 ++++++++++++++++++++++
 tb/tb_axi_cmd_master.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI constants and the command-master FSM state type.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } state_t;

  // True when an INCR burst starting at page offset 'off' runs past the 4 KB page.
  function automatic logic crosses_4k(input logic [11:0] off,
                                      input logic [7:0]  len,
                                      input logic [31:0] bytes);
    logic [31:0] end_b;
    end_b = {20'd0, off} + ((32'(len) + 32'd1) * bytes);
    return end_b > 32'd4096;
  endfunction

endpackage

// File: rtl/axi_cmd_master.sv
// Single-outstanding AXI4 burst master driven by a simple command interface.
// Write/read data beats are passed straight through; responses are accumulated
// and returned once per command on the rsp channel.
module axi_cmd_master
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  // command
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [ID_WIDTH-1:0]     cmd_id,
  // write beats
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  // read beats
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  // completion
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [1:0]              rsp_resp,
  output logic [ID_WIDTH-1:0]     rsp_id,
  // AXI write address
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic [7:0]              AWLEN,
  output logic [2:0]              AWSIZE,
  output logic [1:0]              AWBURST,
  output logic [ID_WIDTH-1:0]     AWID,
  output logic                    AWLOCK,
  output logic [3:0]              AWCACHE,
  output logic [2:0]              AWPROT,
  // AXI write data
  output logic                    WVALID,
  input  logic                    WREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WLAST,
  // AXI write response
  input  logic                    BVALID,
  output logic                    BREADY,
  input  logic [1:0]              BRESP,
  input  logic [ID_WIDTH-1:0]     BID,
  // AXI read address
  output logic                    ARVALID,
  input  logic                    ARREADY,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic [7:0]              ARLEN,
  output logic [2:0]              ARSIZE,
  output logic [1:0]              ARBURST,
  output logic [ID_WIDTH-1:0]     ARID,
  output logic                    ARLOCK,
  output logic [3:0]              ARCACHE,
  output logic [2:0]              ARPROT,
  // AXI read data
  input  logic                    RVALID,
  output logic                    RREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic                    RLAST,
  input  logic [1:0]              RRESP,
  input  logic [ID_WIDTH-1:0]     RID
);

  localparam int         BYTES     = DATA_WIDTH / 8;
  localparam logic [2:0] BEAT_SIZE = 3'($clog2(BYTES));

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [7:0]              len_reg;
  logic [7:0]              cnt_reg;
  logic [ID_WIDTH-1:0]     id_reg;
  logic                    write_reg;
  logic [1:0]              resp_reg;
  logic                    err_reg;
  logic                    awvalid_reg;
  logic                    arvalid_reg;
  logic                    w_hs;
  logic                    r_hs;
  logic                    last_cnt;

  // Handshake qualifiers and beat-position decode.
  assign last_cnt = (cnt_reg == len_reg);
  assign w_hs     = WVALID && WREADY;
  assign r_hs     = RVALID && RREADY;

  // Command / completion side.
  assign cmd_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == DONE);
  assign rsp_resp  = err_reg ? RESP_SLVERR : resp_reg;
  assign rsp_id    = id_reg;

  // Address channels carry the registered command.
  assign AWVALID = awvalid_reg;
  assign AWADDR  = addr_reg;
  assign AWLEN   = len_reg;
  assign AWSIZE  = BEAT_SIZE;
  assign AWBURST = BURST_INCR;
  assign AWID    = id_reg;
  assign AWLOCK  = 1'b0;
  assign AWCACHE = 4'b0011;
  assign AWPROT  = 3'b000;

  assign ARVALID = arvalid_reg;
  assign ARADDR  = addr_reg;
  assign ARLEN   = len_reg;
  assign ARSIZE  = BEAT_SIZE;
  assign ARBURST = BURST_INCR;
  assign ARID    = id_reg;
  assign ARLOCK  = 1'b0;
  assign ARCACHE = 4'b0011;
  assign ARPROT  = 3'b000;

  // Data pass-throughs, opened only in the matching data state.
  assign WVALID   = (state_reg == WR_DATA) && wr_valid;
  assign wr_ready = (state_reg == WR_DATA) && WREADY;
  assign WDATA    = wr_data;
  assign WSTRB    = wr_strb;
  assign WLAST    = (state_reg == WR_DATA) && last_cnt;
  assign BREADY   = (state_reg == WR_RESP);

  assign rd_valid = (state_reg == RD_DATA) && RVALID;
  assign RREADY   = (state_reg == RD_DATA) && rd_ready;
  assign rd_data  = RDATA;
  assign rd_last  = RLAST;

  // Transaction sequencer: captures the command, drives AxVALID, counts beats
  // and folds slave responses/protocol errors into the completion status.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      len_reg     <= '0;
      cnt_reg     <= '0;
      id_reg      <= '0;
      write_reg   <= 1'b0;
      resp_reg    <= RESP_OKAY;
      err_reg     <= 1'b0;
      awvalid_reg <= 1'b0;
      arvalid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            addr_reg  <= cmd_addr;
            len_reg   <= cmd_len;
            id_reg    <= cmd_id;
            write_reg <= cmd_write;
            cnt_reg   <= '0;
            resp_reg  <= RESP_OKAY;
            err_reg   <= 1'b0;
            if (crosses_4k(cmd_addr[11:0], cmd_len, 32'(BYTES))) begin
              // Illegal burst: skip the bus entirely and report SLVERR.
              err_reg   <= 1'b1;
              state_reg <= DONE;
            end else if (cmd_write) begin
              awvalid_reg <= 1'b1;
              state_reg   <= WR_ADDR;
            end else begin
              arvalid_reg <= 1'b1;
              state_reg   <= RD_ADDR;
            end
          end
        end
        WR_ADDR: begin
          if (AWREADY) begin
            awvalid_reg <= 1'b0;
            state_reg   <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (w_hs) begin
            cnt_reg <= cnt_reg + 8'd1;
            if (last_cnt) state_reg <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (BVALID) begin
            resp_reg <= BRESP;
            if (BID != id_reg) err_reg <= 1'b1;
            state_reg <= DONE;
          end
        end
        RD_ADDR: begin
          if (ARREADY) begin
            arvalid_reg <= 1'b0;
            state_reg   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            cnt_reg <= cnt_reg + 8'd1;
            if (RRESP > resp_reg) resp_reg <= RRESP;
            if (RID != id_reg) err_reg <= 1'b1;
            // Either an early RLAST or a missing one at the final beat is an error;
            // beats keep being drained until the slave finally signals RLAST.
            if (RLAST != last_cnt) err_reg <= 1'b1;
            if (RLAST) state_reg <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_cmd_master.sv
// Directed bench for axi_cmd_master with a small always-ready AXI slave model.
module tb_axi_cmd_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic          ACLK;
  logic          ARESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [IW-1:0] cmd_id;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic [3:0]    wr_strb;
  logic          rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic          rsp_valid, rsp_ready;
  logic [1:0]    rsp_resp;
  logic [IW-1:0] rsp_id;
  logic          AWVALID, AWREADY, AWLOCK;
  logic [AW-1:0] AWADDR;
  logic [7:0]    AWLEN;
  logic [2:0]    AWSIZE, AWPROT;
  logic [1:0]    AWBURST;
  logic [IW-1:0] AWID;
  logic [3:0]    AWCACHE;
  logic          WVALID, WREADY, WLAST;
  logic [DW-1:0] WDATA;
  logic [3:0]    WSTRB;
  logic          BVALID, BREADY;
  logic [1:0]    BRESP;
  logic [IW-1:0] BID;
  logic          ARVALID, ARREADY, ARLOCK;
  logic [AW-1:0] ARADDR;
  logic [7:0]    ARLEN;
  logic [2:0]    ARSIZE, ARPROT;
  logic [1:0]    ARBURST;
  logic [IW-1:0] ARID;
  logic [3:0]    ARCACHE;
  logic          RVALID, RREADY, RLAST;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic [IW-1:0] RID;

  axi_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp), .rsp_id(rsp_id),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWID(AWID), .AWLOCK(AWLOCK),
    .AWCACHE(AWCACHE), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .BID(BID),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARID(ARID), .ARLOCK(ARLOCK),
    .ARCACHE(ARCACHE), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RLAST(RLAST),
    .RRESP(RRESP), .RID(RID)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // ---------------- slave model ----------------
  logic [31:0]   mem [0:1023];
  logic [AW-1:0] aw_addr_q, ar_addr_q;
  logic [IW-1:0] aw_id_q;
  logic [9:0]    w_beat, r_beat;
  logic [7:0]    ar_len_q;
  int            aw_hs_cnt, awvalid_cyc, wlast_cnt;
  logic [9:0]    wlast_beat;
  logic [7:0]    aw_len_seen;
  logic [IW-1:0] bid_xor;
  logic [9:0]    rerr_beat;
  logic [9:0]    rlast_extra;
  logic [9:0]    widx, ridx;

  assign AWREADY = 1'b1;
  assign WREADY  = 1'b1;
  assign ARREADY = 1'b1;
  assign BRESP   = 2'b00;
  assign widx    = aw_addr_q[11:2] + w_beat;
  assign ridx    = ar_addr_q[11:2] + r_beat;
  assign RDATA   = mem[ridx];
  assign RLAST   = RVALID && (r_beat == ({2'b00, ar_len_q} + rlast_extra));
  assign RRESP   = (RVALID && r_beat == rerr_beat) ? 2'b10 : 2'b00;

  initial begin
    aw_hs_cnt = 0; awvalid_cyc = 0; wlast_cnt = 0;
    wlast_beat = '0; aw_len_seen = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  end

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      BVALID <= 1'b0; BID <= '0; RVALID <= 1'b0; RID <= '0;
      r_beat <= '0; w_beat <= '0; ar_len_q <= '0;
      aw_addr_q <= '0; ar_addr_q <= '0; aw_id_q <= '0;
    end else begin
      if (AWVALID) awvalid_cyc <= awvalid_cyc + 1;
      if (AWVALID && AWREADY) begin
        aw_addr_q <= AWADDR; aw_id_q <= AWID; w_beat <= '0;
        aw_len_seen <= AWLEN; aw_hs_cnt <= aw_hs_cnt + 1;
      end
      if (WVALID && WREADY) begin
        for (int b = 0; b < 4; b++)
          if (WSTRB[b]) mem[widx][b*8 +: 8] <= WDATA[b*8 +: 8];
        w_beat <= w_beat + 10'd1;
        if (WLAST) begin
          wlast_cnt <= wlast_cnt + 1; wlast_beat <= w_beat;
          BVALID <= 1'b1; BID <= aw_id_q ^ bid_xor;
        end
      end
      if (BVALID && BREADY) BVALID <= 1'b0;
      if (ARVALID && ARREADY) begin
        RVALID <= 1'b1; r_beat <= '0; ar_addr_q <= ARADDR;
        ar_len_q <= ARLEN; RID <= ARID;
      end else if (RVALID && RREADY) begin
        if (RLAST) RVALID <= 1'b0;
        else r_beat <= r_beat + 10'd1;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] got_data [0:15];
  logic        got_last [0:15];
  int          nb;
  int          aw0, wl0, av0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                          input logic [3:0] id);
    int t;
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge ACLK); t++; end
    check("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
    @(posedge ACLK); #1;
    cmd_valid = 1'b0;
    $display("cmd  wr=%0d addr=%0h len=%0d id=%0d", wr, addr, len, id);
  endtask

  task automatic write_beats(input int n, input logic [31:0] base, input logic [31:0] step,
                             input bit rnd);
    int t;
    for (int i = 0; i < n; i++) begin
      @(negedge ACLK);
      if (rnd) begin
        while ($urandom_range(0, 2) == 0) begin wr_valid = 1'b0; @(negedge ACLK); end
      end
      wr_valid = 1'b1; wr_data = base + step * i; wr_strb = 4'hF;
      t = 0;
      while (!wr_ready && t < 50) begin @(negedge ACLK); t++; end
      check("wr_ready_wait", {63'd0, wr_ready}, 64'd1);
      @(posedge ACLK);
      $display("wbeat %0d data=%0h", i, base + step * i);
    end
    @(negedge ACLK);
    wr_valid = 1'b0;
  endtask

  task automatic read_collect(input bit rnd);
    int t;
    nb = 0; t = 0;
    while (t < 200 && nb < 16) begin
      @(negedge ACLK);
      rd_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (rd_valid && rd_ready) begin
        got_data[nb] = rd_data; got_last[nb] = rd_last;
        $display("rbeat %0d data=%0h last=%0d", nb, rd_data, rd_last);
        nb++;
        if (rd_last) break;
      end
      t++;
    end
    @(posedge ACLK); #1;
    rd_ready = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input logic [1:0] exp_resp, input logic [3:0] exp_id,
                          input int limit);
    int t;
    t = 0;
    while (!rsp_valid && t < limit) begin @(negedge ACLK); t++; end
    check({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd1);
    check({tag, "_rsp_resp"}, {62'd0, rsp_resp}, {62'd0, exp_resp});
    check({tag, "_rsp_id"}, {60'd0, rsp_id}, {60'd0, exp_id});
    $display("rsp  %s resp=%0d id=%0d", tag, rsp_resp, rsp_id);
    rsp_ready = 1'b1;
    @(posedge ACLK); #1;
    rsp_ready = 1'b0;
    check({tag, "_idle_after"}, {62'd0, rsp_valid, cmd_ready}, 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    cmd_id = '0; wr_valid = 1'b0; wr_data = '0; wr_strb = '0; rd_ready = 1'b0;
    rsp_ready = 1'b0; bid_xor = '0; rerr_beat = 10'h3FF; rlast_extra = '0;
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_valids", {60'd0, AWVALID, ARVALID, BREADY, rsp_valid}, 64'd0);
    check("rst_rsp", {58'd0, rsp_resp, rsp_id}, 64'd0);
    @(negedge ACLK); ARESET = 1'b0;
    @(posedge ACLK); #1;
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("const_axsize_burst", {59'd0, AWSIZE, AWBURST}, {59'd0, 3'd2, 2'b01});
    check("const_cache_prot", {57'd0, ARCACHE, ARPROT}, {57'd0, 4'b0011, 3'b000});

    // 4-beat write
    aw0 = aw_hs_cnt; wl0 = wlast_cnt;
    send_cmd(1'b1, 32'h10, 8'd3, 4'd5);
    write_beats(4, 32'hA0, 32'h1, 1'b0);
    wait_rsp("wr4", 2'b00, 4'd5, 20);
    check("wr4_awlen", {56'd0, aw_len_seen}, 64'd3);
    check("wr4_wlast_cnt", 64'(wlast_cnt - wl0), 64'd1);
    check("wr4_wlast_beat", {54'd0, wlast_beat}, 64'd3);
    for (int i = 0; i < 4; i++) check("wr4_ram", {32'd0, mem[4+i]}, 64'hA0 + 64'(i));

    // 4-beat read back
    send_cmd(1'b0, 32'h10, 8'd3, 4'd6);
    read_collect(1'b0);
    check("rd4_beats", 64'(nb), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check("rd4_data", {32'd0, got_data[i]}, 64'hA0 + 64'(i));
      check("rd4_last", {63'd0, got_last[i]}, {63'd0, i == 3});
    end
    wait_rsp("rd4", 2'b00, 4'd6, 20);

    // 4 KB crossing: no bus traffic, SLVERR within 2 cycles
    av0 = awvalid_cyc; aw0 = aw_hs_cnt;
    send_cmd(1'b1, 32'hFF8, 8'd3, 4'd1);
    wait_rsp("x4k", 2'b10, 4'd1, 2);
    check("x4k_no_awvalid", 64'(awvalid_cyc - av0), 64'd0);
    check("x4k_no_aw_hs", 64'(aw_hs_cnt - aw0), 64'd0);

    // BID mismatch (slave returns 3 for id 5)
    bid_xor = 4'h6;
    send_cmd(1'b1, 32'h40, 8'd0, 4'd5);
    write_beats(1, 32'h55, 32'h0, 1'b0);
    wait_rsp("bid", 2'b10, 4'd5, 20);
    bid_xor = 4'h0;

    // SLVERR on read beat 2
    rerr_beat = 10'd2;
    send_cmd(1'b0, 32'h10, 8'd3, 4'd7);
    read_collect(1'b0);
    check("rerr_beats", 64'(nb), 64'd4);
    wait_rsp("rerr", 2'b10, 4'd7, 20);
    rerr_beat = 10'h3FF;

    // RLAST arrives one beat late
    rlast_extra = 10'd1;
    send_cmd(1'b0, 32'h10, 8'd1, 4'd2);
    read_collect(1'b0);
    check("late_last_beats", 64'(nb), 64'd3);
    wait_rsp("late_last", 2'b10, 4'd2, 20);
    rlast_extra = 10'd0;

    // 8-beat burst with random stalls on both sides
    send_cmd(1'b1, 32'h80, 8'd7, 4'd9);
    write_beats(8, 32'hC0DE_0000, 32'h0101, 1'b1);
    wait_rsp("wr8", 2'b00, 4'd9, 20);
    send_cmd(1'b0, 32'h80, 8'd7, 4'd9);
    read_collect(1'b1);
    check("rd8_beats", 64'(nb), 64'd8);
    for (int i = 0; i < 8; i++)
      check("rd8_data", {32'd0, got_data[i]}, 64'hC0DE_0000 + 64'(i * 32'h0101));
    wait_rsp("rd8", 2'b00, 4'd9, 20);

    // Reset during WR_DATA beat 2
    send_cmd(1'b1, 32'h100, 8'd3, 4'd7);
    write_beats(2, 32'hB0, 32'h1, 1'b0);
    @(negedge ACLK);
    wr_valid = 1'b1; wr_data = 32'hB2; wr_strb = 4'hF;
    #1;
    check("mid_wvalid_before", {63'd0, WVALID}, 64'd1);
    ARESET = 1'b1;
    #1;
    check("mid_rst_outs", {57'd0, AWVALID, ARVALID, WVALID, WLAST, BREADY, RREADY, rsp_valid}, 64'd0);
    wr_valid = 1'b0;
    aw0 = aw_hs_cnt;
    @(negedge ACLK); ARESET = 1'b0;
    @(posedge ACLK); #1;
    check("mid_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("mid_mem_untouched", {32'd0, mem[66]}, 64'd0);
    send_cmd(1'b1, 32'h200, 8'd0, 4'd2);
    write_beats(1, 32'hD00D, 32'h0, 1'b0);
    wait_rsp("post_rst", 2'b00, 4'd2, 20);
    check("post_rst_aw_hs", 64'(aw_hs_cnt - aw0), 64'd1);
    check("post_rst_ram", {32'd0, mem[128]}, 64'hD00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
